// File: rtl/pool_window_if.sv
// Stream-in / window-out bundle for pool_window.
// The frame_done wire and its modport entries exist only when
// POOL_WINDOW_FRAME_DONE_EN is defined.
interface pool_window_if #(
  parameter int DW = 22
);
  logic                 valid_in;
  logic signed [DW-1:0] data_in;
  logic                 win_valid;
  logic [2*DW-1:0]      x_m_1;
  logic [2*DW-1:0]      x_m_2;
`ifdef POOL_WINDOW_FRAME_DONE_EN
  logic                 frame_done;

  // Producer / consumer side (testbench or upstream/downstream glue)
  modport master (
    output valid_in, data_in,
    input  win_valid, x_m_1, x_m_2, frame_done
  );

  // Window former side
  modport slave (
    input  valid_in, data_in,
    output win_valid, x_m_1, x_m_2, frame_done
  );
`else
  // Producer / consumer side (testbench or upstream/downstream glue)
  modport master (
    output valid_in, data_in,
    input  win_valid, x_m_1, x_m_2
  );

  // Window former side
  modport slave (
    input  valid_in, data_in,
    output win_valid, x_m_1, x_m_2
  );
`endif
endinterface

// File: rtl/pool_window.sv
// pool_window: forms 2x2 max-pool windows from a raster-order sample stream.
// Even rows are parked in a one-line buffer; on odd rows the left sample of
// each column pair is held, and the right sample completes the window,
// which is presented one cycle later on x_m_1 (left column) / x_m_2 (right
// column) with a single-cycle win_valid pulse.
// Optional feature: define POOL_WINDOW_FRAME_DONE_EN to add a frame_done
// pulse coincident with the last window of each frame.
module pool_window #(
  parameter int DW    = 22,
  parameter int IMG_W = 24,
  parameter int IMG_H = 24
) (
  input logic   clk,
  input logic   rst,
  pool_window_if.slave pw
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  // Clears bit 0 of a column index: odd col -> its even partner.
  localparam logic [CW-1:0] PAIR_MASK = ~CW'(1);

  // Raster position of the next sample to be accepted
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // Bottom-left sample of the column pair currently being assembled
  logic [DW-1:0] bl_q, bl_d;

  // Registered window outputs
  logic            win_valid_q, win_valid_d;
  logic [2*DW-1:0] x_m_1_q, x_m_1_d;
  logic [2*DW-1:0] x_m_2_q, x_m_2_d;

  // One even row of samples; never reset, because an even row always
  // refills every entry before an odd row can read it.
  logic [DW-1:0] lbuf_q [IMG_W];
  logic          lb_we;
  logic [CW-1:0] lb_waddr;
  logic [DW-1:0] lb_wdata;

  logic          accept;
  logic          odd_row;
  logic          odd_col;
  logic          col_wrap;
  logic          pair_done;
  logic [CW-1:0] col_left;
  logic [DW-1:0] top_left;
  logic [DW-1:0] top_right;
  logic [DW-1:0] sample;

  assign accept    = pw.valid_in;
  assign sample    = pw.data_in;
  assign odd_row   = row_q[0];
  assign odd_col   = col_q[0];
  assign col_wrap  = (col_q == COL_LAST);
  assign pair_done = accept && odd_row && odd_col;
  assign col_left  = col_q & PAIR_MASK;
  assign top_left  = lbuf_q[col_left];
  assign top_right = lbuf_q[col_q];

  // Raster position counters: advance only on accepted samples
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_wrap) begin
        col_d = '0;
        if (row_q == ROW_LAST) begin
          row_d = '0;
        end else begin
          row_d = row_q + 1'b1;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Line-buffer write port: every even-row sample lands at its column
  always_comb begin
    lb_we    = accept && !odd_row;
    lb_waddr = col_q;
    lb_wdata = sample;
  end

  // Odd row, even column: hold the bottom-left sample until its partner arrives
  always_comb begin
    bl_d = bl_q;
    if (accept && odd_row && !odd_col) begin
      bl_d = sample;
    end
  end

  // Window assembly; outputs keep their last values between pulses
  always_comb begin
    win_valid_d = 1'b0;
    x_m_1_d     = x_m_1_q;
    x_m_2_d     = x_m_2_q;
    if (pair_done) begin
      win_valid_d = 1'b1;
      x_m_1_d     = {top_left, bl_q};
      x_m_2_d     = {top_right, sample};
    end
  end

  // Control and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q       <= '0;
      row_q       <= '0;
      bl_q        <= '0;
      win_valid_q <= 1'b0;
      x_m_1_q     <= '0;
      x_m_2_q     <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      bl_q        <= bl_d;
      win_valid_q <= win_valid_d;
      x_m_1_q     <= x_m_1_d;
      x_m_2_q     <= x_m_2_d;
    end
  end

  // Line-buffer storage; writes are suppressed while reset is held
  always_ff @(posedge clk) begin
    if (lb_we && !rst) begin
      lbuf_q[lb_waddr] <= lb_wdata;
    end
  end

  assign pw.win_valid = win_valid_q;
  assign pw.x_m_1     = x_m_1_q;
  assign pw.x_m_2     = x_m_2_q;

`ifdef POOL_WINDOW_FRAME_DONE_EN
  logic frame_done_q, frame_done_d;

  // Last window of the frame: bottom-right sample of the final row pair
  always_comb begin
    frame_done_d = pair_done && (row_q == ROW_LAST) && col_wrap;
  end

  // frame_done register, cleared with the rest of the control state
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= frame_done_d;
    end
  end

  assign pw.frame_done = frame_done_q;
`endif

endmodule
